window_minmax_tracker: RTL and testbench
========================================

Name: window_minmax_tracker

Overview:
- Downstream consumer of magnitude-compare results.
- Accepts a stream of unsigned WIDTH-bit samples over a valid/ready handshake.
- Groups samples into fixed windows of WIN_LEN and reports each window's maximum, minimum and an all-equal flag over an output valid/ready handshake.
- Feeds the status/display stage; internally uses two magnitude compares per sample.

Parameters:
- WIDTH, 8, sample width in bits; unsigned.
- WIN_LEN, 8, samples per window; legal range 1..255.
- CNT_W, 8, sample-counter width; must hold WIN_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample.
- out_valid  output  1  window result available.
- out_ready  input  1  consumer takes result.
- out_max  output  WIDTH  largest sample in window.
- out_min  output  WIDTH  smallest sample in window.
- out_eq_all  output  1  all samples in window equal (out_max == out_min).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Accept: a sample transfers on a rising edge with in_valid && in_ready. A result transfers on out_valid && out_ready.
- Reset, sampled at the clock edge: state=FIRST, cnt=0, out_max=0, out_min=0, out_eq_all=0, out_valid=0, in_ready=1.
- A reset mid-window or in HOLD discards all partial or pending results, with no output transfer.
- FSM, all registered:
  - FIRST: in_ready=1, out_valid=0. On accept: max=min=in_data, cnt=1. Go to HOLD if WIN_LEN==1, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept:
    - if in_data > max, max=in_data;
    - if in_data < min, min=in_data;
    - equal values update nothing;
    - cnt=cnt+1; when the new cnt == WIN_LEN, go to HOLD.
    - Idle cycles (in_valid=0) hold all state.
  - HOLD: in_ready=0, out_valid=1. out_max, out_min and out_eq_all are stable and driven from the registers. On out_ready go to FIRST with cnt=0. With out_ready=0, hold indefinitely.
- Latency: out_valid rises on the cycle after the edge that accepts the WIN_LEN-th sample.
- Throughput: there is no bypass, so at least 1 bubble per window. Best case is WIN_LEN+1 cycles per window.
- Comparison is unsigned, full WIDTH, with no wrap. Values 0 and 2^WIDTH-1 are legal extremes.
- out_eq_all is computed combinationally from the registered max==min. It is valid only while out_valid=1 and reads 0 otherwise.
- in_ready depends only on state, never on in_valid, so there is no combinational path in→in_ready. out_valid depends on state only.

Optional Feature:
- Macro: MINMAX_INDEX_EN.
- When defined:
  - adds output ports out_max_idx and out_min_idx, each CNT_W wide, giving the 0-based position within the window of the first occurrence of max/min;
  - FIRST loads both indices with 0;
  - ACCUM loads the current cnt into an index when the corresponding strict update occurs;
  - reset value is 0.
- When undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Shared header/package minmax_pkg holds:
  - state encodings FIRST=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - default WIDTH and WIN_LEN constants.
- Sub-module mag_compare:
  - combinational, WIDTH-parameterised;
  - outputs gt, lt, eq;
  - instantiated twice: in_data vs max, and in_data vs min.

Test Plan:
1. WIN_LEN=4, reset, then stream 8'h05, 8'h10, 8'h02, 8'h10 with out_ready=1 → one out_valid pulse: out_max=8'h10, out_min=8'h02, out_eq_all=0. With MINMAX_INDEX_EN: max_idx=1, min_idx=2.
2. WIN_LEN=4, samples all 8'h08 → out_max=out_min=8'h08, out_eq_all=1. With MINMAX_INDEX_EN: both idx=0.
3. Extremes 8'h00, 8'hFF, 8'h80, 8'h7F → out_max=8'hFF, out_min=8'h00. This checks unsigned compare.
4. Backpressure: hold out_ready=0 for 10 cycles after the window completes → in_ready=0 and outputs stable throughout. Raise out_ready → one transfer, then in_ready=1 the next cycle.
5. Gapped input: toggle in_valid every other cycle → result identical to the gapless run, and cnt advances only on accepts.
6. Assert rst after 2 of 4 samples, then send 4 new samples 1,2,3,4 → result max=4, min=1. No output occurs for the aborted window.

Source files
------------

// File: rtl/window_minmax_tracker_pkg.sv
// Shared definitions for window_minmax_tracker: FSM state encoding and default sizing.
package minmax_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_WIN_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/window_minmax_tracker_mag_compare.sv
// Combinational unsigned magnitude comparator reporting a>b, a<b and a==b.
module mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks max/min/all-equal over fixed windows of WIN_LEN unsigned samples.
// Optional first-occurrence index outputs are enabled with macro MINMAX_INDEX_EN.
module window_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int WIN_LEN = DEFAULT_WIN_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic             out_eq_all
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  localparam logic [CNT_W-1:0] WIN_LEN_C = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
`endif

  logic accept;
  logic max_gt, max_lt, max_eq;
  logic min_gt, min_lt, min_eq;
  logic unused_cmp;

  mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
    .a (in_data),
    .b (max_q),
    .gt(max_gt),
    .lt(max_lt),
    .eq(max_eq)
  );

  mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
    .a (in_data),
    .b (min_q),
    .gt(min_gt),
    .lt(min_lt),
    .eq(min_eq)
  );

  // Only the strict outcomes matter: equal samples never move max or min.
  assign unused_cmp = max_lt ^ max_eq ^ min_gt ^ min_eq;
  assign accept     = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef MINMAX_INDEX_EN
    max_idx_d   = max_idx_q;
    min_idx_d   = min_idx_q;
`endif
    case (state_q)
      FIRST: begin
        if (accept) begin
          max_d = in_data;
          min_d = in_data;
          cnt_d = ONE_C;
`ifdef MINMAX_INDEX_EN
          max_idx_d = '0;
          min_idx_d = '0;
`endif
          if (WIN_LEN_C == ONE_C) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (max_gt) begin
            max_d = in_data;
`ifdef MINMAX_INDEX_EN
            max_idx_d = cnt_q;
`endif
          end
          if (min_lt) begin
            min_d = in_data;
`ifdef MINMAX_INDEX_EN
            min_idx_d = cnt_q;
`endif
          end
          cnt_d = cnt_q + ONE_C;
          if (cnt_d == WIN_LEN_C) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = FIRST;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = FIRST;
        cnt_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIRST;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MINMAX_INDEX_EN
      max_idx_q   <= '0;
      min_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MINMAX_INDEX_EN
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_max    = max_q;
  assign out_min    = min_q;
  assign out_eq_all = out_valid_q && (max_q == min_q);
`ifdef MINMAX_INDEX_EN
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Directed self-checking bench for window_minmax_tracker with WIN_LEN=4.
// Index outputs are also checked when built with MINMAX_INDEX_EN.
module tb_window_minmax_tracker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic       out_eq_all;
`ifdef MINMAX_INDEX_EN
  logic [7:0] out_max_idx;
  logic [7:0] out_min_idx;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int transfers  = 0;

  window_minmax_tracker #(.WIDTH(8), .WIN_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_eq_all(out_eq_all)
`ifdef MINMAX_INDEX_EN
    ,
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) transfers++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit gapped);
    if (gapped) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic sendWindow(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3, input bit gapped);
    applyStimulus(s0, gapped);
    applyStimulus(s1, gapped);
    applyStimulus(s2, gapped);
    if (gapped) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("gap_no_early_valid", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(s3, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic checkWindow(input string tag, input logic [7:0] expMax, input logic [7:0] expMin,
                             input logic expEq, input logic [7:0] expMaxIdx, input logic [7:0] expMinIdx);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_max"}, {24'd0, out_max}, {24'd0, expMax});
    checkOutput({tag, "_min"}, {24'd0, out_min}, {24'd0, expMin});
    checkOutput({tag, "_eq"}, {31'd0, out_eq_all}, {31'd0, expEq});
`ifdef MINMAX_INDEX_EN
    checkOutput({tag, "_max_idx"}, {24'd0, out_max_idx}, {24'd0, expMaxIdx});
    checkOutput({tag, "_min_idx"}, {24'd0, out_min_idx}, {24'd0, expMinIdx});
`else
    if (expMaxIdx != expMinIdx) begin end
`endif
  endtask

  task automatic drainWindow(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_drain_eq"}, {31'd0, out_eq_all}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_max", {24'd0, out_max}, 32'd0);
    checkOutput("rst_min", {24'd0, out_min}, 32'd0);
    checkOutput("rst_eq", {31'd0, out_eq_all}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic window");
    sendWindow(8'h05, 8'h10, 8'h02, 8'h10, 1'b0);
    checkWindow("t1", 8'h10, 8'h02, 1'b0, 8'd1, 8'd2);
    drainWindow("t1");

    $display("[TB] all equal");
    sendWindow(8'h08, 8'h08, 8'h08, 8'h08, 1'b0);
    checkWindow("t2", 8'h08, 8'h08, 1'b1, 8'd0, 8'd0);
    drainWindow("t2");

    $display("[TB] unsigned extremes");
    sendWindow(8'h00, 8'hFF, 8'h80, 8'h7F, 1'b0);
    checkWindow("t3", 8'hFF, 8'h00, 1'b0, 8'd1, 8'd0);
    drainWindow("t3");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    sendWindow(8'h03, 8'h07, 8'h01, 8'h07, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkWindow("t4_hold", 8'h07, 8'h01, 1'b0, 8'd1, 8'd2);
    end
    in_valid = 1'b0;
    drainWindow("t4");
    checkOutput("t4_transfers", transfers, 32'd4);

    $display("[TB] gapped input");
    sendWindow(8'h05, 8'h10, 8'h02, 8'h10, 1'b1);
    checkWindow("t5", 8'h10, 8'h02, 1'b0, 8'd1, 8'd2);
    drainWindow("t5");

    $display("[TB] reset mid-window");
    applyStimulus(8'h09, 1'b0);
    applyStimulus(8'h00, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_rst_max", {24'd0, out_max}, 32'd0);
    sendWindow(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    checkWindow("t6", 8'd4, 8'd1, 1'b0, 8'd3, 8'd0);
    drainWindow("t6");
    checkOutput("total_transfers", transfers, 32'd6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
